// File: rtl/sfifo_wconv_up.sv
// Single-clock FIFO that packs RATIO narrow write words into one wide read word.
// Supports flush of partially packed words (with a valid-lane count) and sticky error flags.
module sfifo_wconv_up #(
  parameter int unsigned WR_DATA_WIDTH    = 16,
  parameter int unsigned RATIO            = 16,
  parameter int unsigned RD_DEPTH_WIDTH   = 8,
  parameter int unsigned ALMOST_FULL_NUM  = 4092,
  parameter int unsigned ALMOST_EMPTY_NUM = 4,
  parameter int unsigned OUTPUT_REG       = 0,
  localparam int unsigned RD_DATA_WIDTH   = WR_DATA_WIDTH * RATIO,
  localparam int unsigned LW              = $clog2(RATIO),
  localparam int unsigned WR_DEPTH_WIDTH  = RD_DEPTH_WIDTH + LW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  input  logic                      flush,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic [LW:0]               rd_lanes,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PCW   = (LW > 0) ? LW : 1;
  localparam int unsigned DEPTH = 2 ** RD_DEPTH_WIDTH;
  localparam int unsigned MW    = RD_DATA_WIDTH + LW + 1;
  localparam int unsigned WLW   = WR_DEPTH_WIDTH + 1;
  localparam int unsigned CW    = RD_DEPTH_WIDTH + 1;

  logic [RD_DEPTH_WIDTH-1:0] r_wptr, r_rptr;
  logic [CW-1:0]             r_ram_cnt;
  logic [PCW-1:0]            r_pack_cnt;
  logic [RD_DATA_WIDTH-1:0]  r_pack;
  logic [MW-1:0]             r_mem [DEPTH];
  logic [MW-1:0]             r_rd_q;
  logic                      r_overflow, r_underflow;

  logic                      w_wr_acc, w_rd_acc, w_last, w_commit;
  logic [RD_DATA_WIDTH-1:0]  w_pack;
  logic [LW:0]               w_lanes;

  assign w_wr_acc = wr_en & ~wr_full;
  assign w_rd_acc = rd_en & ~rd_empty;
  assign w_last   = (r_pack_cnt == (PCW)'(RATIO - 1));
  assign w_lanes  = (LW + 1)'(r_pack_cnt) + (LW + 1)'(w_wr_acc);
  // A flush commits whatever is packed, including a write accepted on the same edge.
  assign w_commit = (w_wr_acc & w_last) | (flush & (w_wr_acc | (r_pack_cnt != '0)));

  always_comb begin
    w_pack = r_pack;
    if (w_wr_acc) begin
      w_pack[32'(r_pack_cnt) * WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ram_cnt   <= '0;
      r_pack_cnt  <= '0;
      r_pack      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_q      <= '0;
    end else begin
      // Packed lanes are cleared on commit so a later flush leaves unused lanes zero.
      if (w_commit) begin
        r_pack     <= '0;
        r_pack_cnt <= '0;
        r_wptr     <= r_wptr + (RD_DEPTH_WIDTH)'(1);
      end else if (w_wr_acc) begin
        r_pack     <= w_pack;
        r_pack_cnt <= r_pack_cnt + (PCW)'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + (RD_DEPTH_WIDTH)'(1);
        r_rd_q <= r_mem[r_rptr];
      end
      case ({w_commit, w_rd_acc})
        2'b10:   r_ram_cnt <= r_ram_cnt + (CW)'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - (CW)'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      if (wr_en & wr_full)  r_overflow  <= 1'b1;
      if (rd_en & rd_empty) r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_wptr] <= {w_lanes, w_pack};
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic          r_rd_v;
      logic [MW-1:0] r_out;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_v <= 1'b0;
          r_out  <= '0;
        end else begin
          r_rd_v <= w_rd_acc;
          if (r_rd_v) r_out <= r_rd_q;
        end
      end
      assign {rd_lanes, rd_data} = r_out;
    end else begin : g_no_out_reg
      assign {rd_lanes, rd_data} = r_rd_q;
    end
  endgenerate

  assign wr_water_level = ((WLW)'(r_ram_cnt) << LW) + (WLW)'(r_pack_cnt);
  assign wr_full        = wr_water_level[WR_DEPTH_WIDTH];
  assign almost_full    = 32'(wr_water_level) >= ALMOST_FULL_NUM;
  assign rd_water_level = r_ram_cnt;
  assign rd_empty       = (r_ram_cnt == '0);
  assign almost_empty   = 32'(r_ram_cnt) <= ALMOST_EMPTY_NUM;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;

endmodule

// File: tb/tb_sfifo_wconv_up.sv
// Scoreboard bench for sfifo_wconv_up: default 16x16 instance plus a 8-bit x4 instance
// with the extra output register.
module tb_sfifo_wconv_up;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A: default parameters
  logic         rst_a, wr_en_a, flush_a, rd_en_a;
  logic [15:0]  wr_data_a;
  logic         wr_full_a, af_a, rd_empty_a, ae_a, ovf_a, unf_a;
  logic [12:0]  wr_lvl_a;
  logic [255:0] rd_data_a;
  logic [4:0]   rd_lanes_a;
  logic [8:0]   rd_lvl_a;

  sfifo_wconv_up u_dut_a (
    .clk(clk), .rst(rst_a), .wr_data(wr_data_a), .wr_en(wr_en_a), .flush(flush_a),
    .wr_full(wr_full_a), .wr_water_level(wr_lvl_a), .almost_full(af_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .rd_lanes(rd_lanes_a), .rd_empty(rd_empty_a),
    .rd_water_level(rd_lvl_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a)
  );

  // Instance B: RATIO=4, 8-bit words, output register
  logic         rst_b, wr_en_b, flush_b, rd_en_b;
  logic [7:0]   wr_data_b;
  logic         wr_full_b, af_b, rd_empty_b, ae_b, ovf_b, unf_b;
  logic [10:0]  wr_lvl_b;
  logic [31:0]  rd_data_b;
  logic [2:0]   rd_lanes_b;
  logic [8:0]   rd_lvl_b;

  sfifo_wconv_up #(
    .WR_DATA_WIDTH(8), .RATIO(4), .RD_DEPTH_WIDTH(8), .ALMOST_FULL_NUM(1020),
    .ALMOST_EMPTY_NUM(4), .OUTPUT_REG(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .flush(flush_b),
    .wr_full(wr_full_b), .wr_water_level(wr_lvl_b), .almost_full(af_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .rd_lanes(rd_lanes_b), .rd_empty(rd_empty_b),
    .rd_water_level(rd_lvl_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b)
  );

  // Reference model for A: committed words and the pack register
  logic [260:0] m_q[$];
  logic [260:0] exp_qa[$];
  logic [34:0]  exp_qb[$];
  logic [255:0] m_pack = '0;
  int           m_cnt = 0;

  task automatic chk(input string name, input logic [263:0] got, input logic [263:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc_a(input bit we, input logic [15:0] d, input bit fl, input bit re);
    bit full;
    full = (m_q.size() * 16 + m_cnt) == 4096;
    wr_en_a = we; wr_data_a = d; flush_a = fl; rd_en_a = re;
    if (re && m_q.size() > 0) exp_qa.push_back(m_q.pop_front());
    if (we && !full) begin
      m_pack[m_cnt*16 +: 16] = d;
      m_cnt++;
    end
    if (m_cnt == 16 || (fl && m_cnt > 0)) begin
      m_q.push_back({5'(m_cnt), m_pack});
      m_pack = '0;
      m_cnt = 0;
    end
    @(posedge clk); #1;
    wr_en_a = 1'b0; flush_a = 1'b0; rd_en_a = 1'b0;
  endtask

  task automatic chk_reset_a();
    chk("rst_rd_empty", rd_empty_a, 1);
    chk("rst_wr_full", wr_full_a, 0);
    chk("rst_almost_empty", ae_a, 1);
    chk("rst_almost_full", af_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_underflow", unf_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_rd_lanes", rd_lanes_a, 0);
    chk("rst_wr_level", wr_lvl_a, 0);
    chk("rst_rd_level", rd_lvl_a, 0);
  endtask

  // Monitors: a read accepted at an edge presents data after 1 (A) or 2 (B) edges.
  logic va = 1'b0, vb1 = 1'b0, vb2 = 1'b0;
  always @(posedge clk) begin
    va  <= !rst_a && rd_en_a && !rd_empty_a;
    vb1 <= !rst_b && rd_en_b && !rd_empty_b;
    vb2 <= vb1 && !rst_b;
  end

  always @(negedge clk) begin
    logic [260:0] ea;
    logic [34:0]  eb;
    if (va) begin
      if (exp_qa.size() == 0) chk("mon_a_unexpected", {rd_lanes_a, rd_data_a}, 0);
      else begin
        ea = exp_qa.pop_front();
        chk("mon_a_word", {rd_lanes_a, rd_data_a}, ea);
      end
    end
    if (vb2) begin
      if (exp_qb.size() == 0) chk("mon_b_unexpected", {rd_lanes_b, rd_data_b}, 0);
      else begin
        eb = exp_qb.pop_front();
        chk("mon_b_word", {rd_lanes_b, rd_data_b}, eb);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; wr_en_a = 0; flush_a = 0; rd_en_a = 0; wr_data_a = '0;
    rst_b = 1'b1; wr_en_b = 0; flush_b = 0; rd_en_b = 0; wr_data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a();
    chk("rst_b_rd_empty", rd_empty_b, 1);
    rst_a = 1'b0; rst_b = 1'b0;

    // Fill to full with descending data
    for (int i = 0; i < 4096; i++) begin
      cyc_a(1, 16'(16'hFFFF - i), 0, 0);
      if (i == 4090) chk("af_below", af_a, 0);
      if (i == 4091) chk("af_at_4092", af_a, 1);
      if (i == 4094) chk("not_full_4095", wr_full_a, 0);
    end
    chk("full_after_4096", wr_full_a, 1);
    chk("rd_level_256", rd_lvl_a, 256);
    chk("wr_level_4096", wr_lvl_a, 4096);
    chk("no_overflow_yet", ovf_a, 0);
    cyc_a(1, 16'h1234, 0, 0);
    chk("overflow_set", ovf_a, 1);
    chk("wr_level_held", wr_lvl_a, 4096);

    // Drain
    cyc_a(0, 0, 0, 1);
    chk("first_lane0", rd_data_a[15:0], 16'hFFFF);
    chk("first_lane15", rd_data_a[255:240], 16'hFFF0);
    chk("first_lanes", rd_lanes_a, 16);
    chk("not_full_after_read", wr_full_a, 0);
    for (int i = 1; i < 256; i++) cyc_a(0, 0, 0, 1);
    chk("empty_after_256", rd_empty_a, 1);
    chk("no_underflow_yet", unf_a, 0);
    cyc_a(0, 0, 0, 1);
    chk("underflow_set", unf_a, 1);
    chk("rd_data_hold", rd_data_a[15:0], 16'hF00F);

    // Partial word flush
    for (int i = 1; i <= 5; i++) cyc_a(1, 16'(i), 0, 0);
    chk("pack_not_readable", rd_empty_a, 1);
    cyc_a(0, 0, 1, 0);
    chk("flush_not_empty", rd_empty_a, 0);
    chk("flush_wr_level", wr_lvl_a, 16);
    chk("flush_ae", ae_a, 1);
    cyc_a(0, 0, 1, 0);
    chk("flush2_wr_level", wr_lvl_a, 16);
    chk("flush2_rd_level", rd_lvl_a, 1);
    cyc_a(0, 0, 0, 1);
    chk("flush_lanes", rd_lanes_a, 5);
    chk("flush_low", rd_data_a[79:0], 80'h0005_0004_0003_0002_0001);
    chk("flush_high_zero", rd_data_a[255:80], 0);

    // Same-edge commit and read
    for (int i = 0; i < 175; i++) cyc_a(1, 16'(16'h4000 + i), 0, 0);
    chk("rd_level_10", rd_lvl_a, 10);
    chk("ae_clear_10", ae_a, 0);
    cyc_a(1, 16'h40AF, 0, 1);
    chk("rd_level_stays_10", rd_lvl_a, 10);
    for (int i = 0; i < 10; i++) cyc_a(0, 0, 0, 1);
    chk("empty_after_drain", rd_empty_a, 1);

    // Mid-operation reset
    for (int i = 0; i < 100; i++) cyc_a(1, 16'(16'h7000 + i), 0, 0);
    chk("wr_level_100", wr_lvl_a, 100);
    chk("overflow_sticky", ovf_a, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    m_q.delete(); exp_qa.delete(); m_pack = '0; m_cnt = 0;
    chk_reset_a();
    for (int i = 0; i < 16; i++) cyc_a(1, 16'(16'hA000 + i), 0, 0);
    cyc_a(0, 0, 0, 1);
    chk("post_rst_lane0", rd_data_a[15:0], 16'hA000);

    // Instance B: latency 2 with output register
    for (int i = 1; i <= 4; i++) begin
      wr_en_b = 1'b1; wr_data_b = 8'(8'h11 * i);
      @(posedge clk); #1;
    end
    wr_en_b = 1'b0;
    rd_en_b = 1'b1;
    exp_qb.push_back({3'd4, 32'h4433_2211});
    @(posedge clk); #1;
    rd_en_b = 1'b0;
    chk("b_latency_not_1", rd_data_b, 0);
    @(posedge clk); #1;
    chk("b_data", rd_data_b, 32'h4433_2211);
    chk("b_lanes", rd_lanes_b, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", exp_qa.size(), 0);
    chk("b_queue_drained", exp_qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
